datapath_sequencer: RTL and testbench

- Multi-cycle control FSM for the lab datapath: the instruction decoder, the 32x32 register file and the ALU.
- Drives the decoder's fetch/advance strobe and latches each 32-bit instruction into an internal IR.
- Decodes the opcode and register fields, then sequences register read, ALU execute and register write-back.
- Stops on an all-zero word, an instruction-count limit or an illegal opcode.

---
 rtl/seq_pkg.sv | 31 +++
 rtl/instr_field_decode.sv | 31 +++
 rtl/datapath_sequencer.sv | 124 ++++++++++++
 tb/tb_datapath_sequencer.sv | 348 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_pkg.sv
// Shared definitions for the datapath sequencer: opcodes, instruction field
// positions and the controller state encoding.
package seq_pkg;

  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_SHL  = 3'b100;
  localparam logic [2:0] OP_ADDI = 3'b110;
  localparam logic [2:0] OP_SUBI = 3'b111;

  localparam int OP_MSB  = 31;
  localparam int OP_LSB  = 29;
  localparam int RS_MSB  = 28;
  localparam int RS_LSB  = 24;
  localparam int RT_MSB  = 23;
  localparam int RT_LSB  = 19;
  localparam int RD_MSB  = 18;
  localparam int RD_LSB  = 14;
  localparam int IMM_MSB = 15;
  localparam int IMM_LSB = 0;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_WB     = 3'd4,
    ST_DONE   = 3'd5,
    ST_ERROR  = 3'd6
  } state_t;

endpackage

// File: rtl/instr_field_decode.sv
// Combinational split of the latched instruction word into register fields,
// immediate and format/legality flags.
module instr_field_decode
  import seq_pkg::*;
(
  input  logic [31:0] ir,
  output logic [2:0]  op,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [4:0]  rd,
  output logic [15:0] imm,
  output logic        is_rtype,
  output logic        is_itype,
  output logic        is_end,
  output logic        is_illegal
);

  always_comb begin
    op         = ir[OP_MSB:OP_LSB];
    rs         = ir[RS_MSB:RS_LSB];
    rt         = ir[RT_MSB:RT_LSB];
    rd         = ir[RD_MSB:RD_LSB];
    imm        = ir[IMM_MSB:IMM_LSB];
    is_rtype   = (op == OP_ADD) || (op == OP_SHL);
    is_itype   = (op == OP_ADDI) || (op == OP_SUBI);
    is_end     = (ir == 32'd0);
    // opcode 000 with stray bits set is treated like any other unknown opcode
    is_illegal = !is_rtype && !is_itype && !is_end;
  end

endmodule

// File: rtl/datapath_sequencer.sv
// Multi-cycle controller: fetches instruction words from the decoder, then
// sequences register read, ALU execute and register write-back.
module datapath_sequencer
  import seq_pkg::*;
#(
  parameter int PROG_LEN    = 32,
  parameter int EXEC_CYCLES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] instruction,
  output logic        fetch_en,
  output logic [4:0]  rf_ra,
  output logic [4:0]  rf_rb,
  output logic [4:0]  rf_wa,
  output logic        rf_we,
  output logic [2:0]  alu_op,
  output logic        alu_src_imm,
  output logic [31:0] imm_ext,
  output logic        busy,
  output logic        done,
  output logic        illegal,
  output logic [5:0]  instr_count,
  output logic [2:0]  state_dbg
);

  localparam logic [3:0] EXEC_LOAD  = 4'(EXEC_CYCLES - 1);
  localparam logic [6:0] PROG_LEN_W = 7'(PROG_LEN);

  state_t      state, state_nx;
  logic [31:0] ir;
  logic [3:0]  exec_cnt;
  logic [5:0]  count_q;

  logic [2:0]  op;
  logic [4:0]  rs, rt, rd, dest;
  logic [15:0] imm;
  logic        is_rtype, is_itype, is_end, is_illegal;
  logic        run_start, last_retire;

  instr_field_decode u_decode (
    .ir         (ir),
    .op         (op),
    .rs         (rs),
    .rt         (rt),
    .rd         (rd),
    .imm        (imm),
    .is_rtype   (is_rtype),
    .is_itype   (is_itype),
    .is_end     (is_end),
    .is_illegal (is_illegal)
  );

  assign dest        = is_rtype ? rd : rt;
  assign run_start   = start && ((state == ST_IDLE) || (state == ST_DONE));
  assign last_retire = ({1'b0, count_q} + 7'd1) == PROG_LEN_W;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      ir       <= 32'd0;
      exec_cnt <= 4'd0;
      count_q  <= 6'd0;
    end else begin
      state <= state_nx;
      if (state == ST_FETCH) ir <= instruction;
      if (state == ST_DECODE)
        exec_cnt <= EXEC_LOAD;
      else if ((state == ST_EXEC) && (exec_cnt != 4'd0))
        exec_cnt <= exec_cnt - 4'd1;
      if (run_start)
        count_q <= 6'd0;
      else if ((state == ST_WB) && ({1'b0, count_q} < PROG_LEN_W))
        count_q <= count_q + 6'd1;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:   if (start) state_nx = ST_FETCH;
      ST_FETCH:  state_nx = ST_DECODE;
      ST_DECODE: begin
        if (is_end)          state_nx = ST_DONE;
        else if (is_illegal) state_nx = ST_ERROR;
        else                 state_nx = ST_EXEC;
      end
      ST_EXEC:   if (exec_cnt == 4'd0) state_nx = ST_WB;
      ST_WB:     state_nx = last_retire ? ST_DONE : ST_FETCH;
      ST_DONE:   if (start) state_nx = ST_FETCH;
      ST_ERROR:  state_nx = ST_ERROR;
      default:   state_nx = ST_IDLE;
    endcase
  end

  always_comb begin
    fetch_en    = (state == ST_FETCH);
    rf_ra       = 5'd0;
    rf_rb       = 5'd0;
    rf_wa       = 5'd0;
    rf_we       = 1'b0;
    alu_op      = 3'd0;
    alu_src_imm = 1'b0;
    imm_ext     = 32'd0;
    // datapath controls follow IR from DECODE until write-back completes
    if ((state == ST_DECODE) || (state == ST_EXEC) || (state == ST_WB)) begin
      rf_ra       = rs;
      rf_rb       = is_rtype ? rt : 5'd0;
      rf_wa       = dest;
      alu_op      = op;
      alu_src_imm = is_itype;
      imm_ext     = {16'd0, imm};
      rf_we       = (state == ST_WB) && (dest != 5'd0);
    end
    busy        = (state == ST_FETCH) || (state == ST_DECODE) ||
                  (state == ST_EXEC)  || (state == ST_WB);
    done        = (state == ST_DONE);
    illegal     = (state == ST_ERROR);
    instr_count = count_q;
    state_dbg   = state;
  end

endmodule

// File: tb/tb_datapath_sequencer.sv
// Bench for datapath_sequencer: instruction memories standing in for the decoder,
// a program-level reference model and per-cycle output checking.
module tb_datapath_sequencer;
  import seq_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // ---------------- DUT A (EXEC_CYCLES=1) ----------------
  logic        start_a = 1'b0;
  logic [31:0] instr_a, imm_a;
  logic        fetch_a, we_a, src_a, busy_a, done_a, ill_a;
  logic [4:0]  ra_a, rb_a, wa_a;
  logic [2:0]  op_a, st_a;
  logic [5:0]  cnt_a;
  logic [31:0] mem_a [64];
  logic [5:0]  pc_a;

  datapath_sequencer dut_a (
    .clk(clk), .reset(reset), .start(start_a), .instruction(instr_a),
    .fetch_en(fetch_a), .rf_ra(ra_a), .rf_rb(rb_a), .rf_wa(wa_a), .rf_we(we_a),
    .alu_op(op_a), .alu_src_imm(src_a), .imm_ext(imm_a), .busy(busy_a),
    .done(done_a), .illegal(ill_a), .instr_count(cnt_a), .state_dbg(st_a)
  );

  assign instr_a = mem_a[pc_a];
  always @(posedge clk or posedge reset)
    if (reset) pc_a <= 6'd0;
    else if (fetch_a) pc_a <= pc_a + 6'd1;

  // ---------------- DUT B (EXEC_CYCLES=3) ----------------
  logic        start_b = 1'b0;
  logic [31:0] instr_b, imm_b;
  logic        fetch_b, we_b, src_b, busy_b, done_b, ill_b;
  logic [4:0]  ra_b, rb_b, wa_b;
  logic [2:0]  op_b, st_b;
  logic [5:0]  cnt_b;
  logic [31:0] mem_b [64];
  logic [5:0]  pc_b;

  datapath_sequencer #(.EXEC_CYCLES(3)) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .instruction(instr_b),
    .fetch_en(fetch_b), .rf_ra(ra_b), .rf_rb(rb_b), .rf_wa(wa_b), .rf_we(we_b),
    .alu_op(op_b), .alu_src_imm(src_b), .imm_ext(imm_b), .busy(busy_b),
    .done(done_b), .illegal(ill_b), .instr_count(cnt_b), .state_dbg(st_b)
  );

  assign instr_b = mem_b[pc_b];
  always @(posedge clk or posedge reset)
    if (reset) pc_b <= 6'd0;
    else if (fetch_b) pc_b <= pc_b + 6'd1;

  // ---------------- helpers / model ----------------
  logic [4:0] exp_q[$];
  logic [4:0] exp_qb[$];
  logic [4:0] act_wa[$];
  int we_cnt_a = 0, we_cnt_b = 0, fetch_cnt_b = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] rtyp(logic [2:0] op, logic [4:0] rd, logic [4:0] rs, logic [4:0] rt);
    return {op, rs, rt, rd, 14'd0};
  endfunction

  function automatic logic [31:0] ityp(logic [2:0] op, logic [4:0] rt, logic [4:0] rs, logic [15:0] imm);
    return {op, rs, rt, 3'd0, imm};
  endfunction

  function automatic bit is_r(logic [31:0] w);
    return (w[31:29] == 3'b010) || (w[31:29] == 3'b100);
  endfunction

  function automatic bit is_i(logic [31:0] w);
    return (w[31:29] == 3'b110) || (w[31:29] == 3'b111);
  endfunction

  // Walks the program from idx as the architecture defines a run and queues
  // every register write that must appear; n = instructions that must retire.
  task automatic model_run(input int idx, output int n);
    logic [31:0] w;
    logic [4:0]  d;
    n = 0;
    for (int k = 0; k < 32; k++) begin
      w = mem_a[(idx + k) % 64];
      if (w == 32'd0) break;
      if (!is_r(w) && !is_i(w)) break;
      d = is_r(w) ? w[18:14] : w[23:19];
      if (d != 5'd0) exp_q.push_back(d);
      n++;
    end
  endtask

  // ---------------- compare process A ----------------
  int          last_fa = -1;
  bit          dec_pending = 0;
  logic [31:0] dec_word;

  always @(negedge clk) begin
    if (reset) begin
      last_fa = -1;
      dec_pending = 0;
      exp_q.delete();
    end else begin
      if (dec_pending) begin
        dec_pending = 0;
        if (is_r(dec_word) || is_i(dec_word)) begin
          chk("dec_ra", ra_a, dec_word[28:24]);
          chk("dec_rb", rb_a, is_r(dec_word) ? dec_word[23:19] : 5'd0);
          chk("dec_op", op_a, dec_word[31:29]);
          chk("dec_src", src_a, is_i(dec_word));
          chk("dec_imm", imm_a, {16'd0, dec_word[15:0]});
        end
      end
      if (we_a) begin
        we_cnt_a++;
        act_wa.push_back(wa_a);
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_wb actual=%0d required=none", wa_a);
        end else chk("wb_wa", wa_a, exp_q.pop_front());
      end
      if (fetch_a) begin
        if (last_fa >= 0) chk("fetch_gap_a", cyc - last_fa, 4);
        last_fa = cyc;
        dec_pending = 1;
        dec_word = instr_a;
      end
      if (!busy_a) last_fa = -1;
    end
  end

  // ---------------- compare process B ----------------
  int last_fb = -1;
  always @(negedge clk) begin
    if (reset) begin
      last_fb = -1;
    end else begin
      if (we_b) begin
        we_cnt_b++;
        if (exp_qb.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_wb_b actual=%0d required=none", wa_b);
        end else chk("wb_wa_b", wa_b, exp_qb.pop_front());
      end
      if (fetch_b) begin
        fetch_cnt_b++;
        if (last_fb >= 0) chk("fetch_gap_b", cyc - last_fb, 6);
        last_fb = cyc;
      end
      if (!busy_b) last_fb = -1;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    act_wa.delete();
  endtask

  task automatic clear_mem_a();
    for (int i = 0; i < 64; i++) mem_a[i] = 32'd0;
  endtask

  task automatic pulse_start_a();
    @(negedge clk) start_a = 1'b1;
    @(negedge clk) start_a = 1'b0;
  endtask

  task automatic wait_end(input bit sel_b, input int budget, input string name);
    int k;
    for (k = 0; k < budget; k++) begin
      @(negedge clk);
      if (sel_b ? (done_b || ill_b) : (done_a || ill_a)) break;
    end
    if (k == budget) begin
      checks++; errors++;
      $display("FAIL %s_timeout actual=%0d required<%0d", name, k, budget);
    end
  endtask

  task automatic check_all_zero_a(input string name);
    chk({name, "_fetch"}, fetch_a, 1'b0);
    chk({name, "_ra"}, ra_a, 5'd0);
    chk({name, "_rb"}, rb_a, 5'd0);
    chk({name, "_wa"}, wa_a, 5'd0);
    chk({name, "_we"}, we_a, 1'b0);
    chk({name, "_op"}, op_a, 3'd0);
    chk({name, "_src"}, src_a, 1'b0);
    chk({name, "_imm"}, imm_a, 32'd0);
    chk({name, "_busy"}, busy_a, 1'b0);
    chk({name, "_done"}, done_a, 1'b0);
    chk({name, "_ill"}, ill_a, 1'b0);
    chk({name, "_cnt"}, cnt_a, 6'd0);
    chk({name, "_state"}, st_a, ST_IDLE);
  endtask

  // ---------------- stimulus ----------------
  logic [4:0]  lit_wa [6] = '{5'd10, 5'd15, 5'd25, 5'd20, 5'd5, 5'd30};
  logic [31:0] bad_words [2] = '{32'h2000_0000, 32'h0000_0001};

  initial begin
    int n, snap;
    clear_mem_a();
    for (int i = 0; i < 64; i++)
      mem_b[i] = (i < 32) ? ityp(3'b110, 5'((i % 31) + 1), 5'd0, 16'(i + 1)) : 32'h2000_0000;
    do_reset();
    check_all_zero_a("reset");
    chk("reset_b_busy", busy_b, 1'b0);
    chk("reset_b_cnt", cnt_b, 6'd0);

    // Test 1: six-instruction program, then a second run continuing from the next word
    mem_a[0] = ityp(3'b110, 5'd10, 5'd0, 16'd10);
    mem_a[1] = ityp(3'b110, 5'd15, 5'd0, 16'd15);
    mem_a[2] = rtyp(3'b010, 5'd25, 5'd10, 5'd15);
    mem_a[3] = ityp(3'b111, 5'd20, 5'd25, 16'd5);
    mem_a[4] = ityp(3'b110, 5'd5, 5'd0, 16'd2);
    mem_a[5] = rtyp(3'b100, 5'd30, 5'd25, 5'd5);
    mem_a[6] = 32'd0;
    mem_a[7] = ityp(3'b110, 5'd3, 5'd0, 16'd1);
    mem_a[8] = 32'd0;
    model_run(0, n);
    pulse_start_a();
    wait_end(0, 100, "t1");
    chk("t1_done", done_a, 1'b1);
    chk("t1_busy", busy_a, 1'b0);
    chk("t1_cnt_lit", cnt_a, 6'd6);
    chk("t1_cnt_model", cnt_a, n);
    chk("t1_nwb", act_wa.size(), 6);
    for (int i = 0; i < 6; i++)
      if (i < act_wa.size()) chk($sformatf("t1_wa%0d", i), act_wa[i], lit_wa[i]);
    chk("t1_expq_empty", exp_q.size(), 0);
    act_wa.delete();
    model_run(7, n);
    pulse_start_a();
    wait_end(0, 50, "t1b");
    chk("t1b_done", done_a, 1'b1);
    chk("t1b_cnt", cnt_a, 6'd1);
    chk("t1b_wa", (act_wa.size() > 0) ? act_wa[0] : 5'd0, 5'd3);

    // Test 2: ADD r25,r10,r15 decode fields and write address
    do_reset();
    clear_mem_a();
    mem_a[0] = rtyp(3'b010, 5'd25, 5'd10, 5'd15);
    model_run(0, n);
    pulse_start_a();
    @(negedge clk);
    chk("t2_ra", ra_a, 5'd10);
    chk("t2_rb", rb_a, 5'd15);
    chk("t2_src", src_a, 1'b0);
    chk("t2_op", op_a, 3'b010);
    wait_end(0, 50, "t2");
    chk("t2_wa", (act_wa.size() > 0) ? act_wa[0] : 5'd0, 5'd25);
    chk("t2_cnt", cnt_a, 6'd1);

    // Test 3: ADDI r0,r0,7 retires without a register write
    do_reset();
    clear_mem_a();
    mem_a[0] = ityp(3'b110, 5'd0, 5'd0, 16'd7);
    model_run(0, n);
    snap = we_cnt_a;
    pulse_start_a();
    @(negedge clk);
    chk("t3_imm", imm_a, 32'h7);
    chk("t3_src", src_a, 1'b1);
    chk("t3_rb", rb_a, 5'd0);
    wait_end(0, 50, "t3");
    chk("t3_we_none", we_cnt_a - snap, 0);
    chk("t3_cnt", cnt_a, 6'd1);
    chk("t3_done", done_a, 1'b1);

    // Test 4: illegal words stop in ERROR; start ignored; reset clears
    foreach (bad_words[j]) begin
      do_reset();
      clear_mem_a();
      mem_a[0] = bad_words[j];
      mem_a[1] = ityp(3'b110, 5'd9, 5'd0, 16'd1);
      snap = we_cnt_a;
      pulse_start_a();
      wait_end(0, 50, "t4");
      chk("t4_illegal", ill_a, 1'b1);
      chk("t4_busy", busy_a, 1'b0);
      chk("t4_done", done_a, 1'b0);
      pulse_start_a();
      repeat (5) @(negedge clk);
      chk("t4_still_illegal", ill_a, 1'b1);
      chk("t4_state", st_a, ST_ERROR);
      chk("t4_no_fetch", pc_a, 6'd1);
      chk("t4_we_none", we_cnt_a - snap, 0);
      reset = 1'b1;
      @(negedge clk);
      chk("t4_reset_clears", ill_a, 1'b0);
    end

    // Test 5: reset during EXEC of instruction 3 drops its write-back
    do_reset();
    clear_mem_a();
    mem_a[0] = ityp(3'b110, 5'd10, 5'd0, 16'd10);
    mem_a[1] = ityp(3'b110, 5'd15, 5'd0, 16'd15);
    mem_a[2] = rtyp(3'b010, 5'd25, 5'd10, 5'd15);
    mem_a[3] = ityp(3'b111, 5'd20, 5'd25, 16'd5);
    model_run(0, n);
    snap = we_cnt_a;
    pulse_start_a();
    repeat (10) @(negedge clk);
    chk("t5_in_exec", st_a, ST_EXEC);
    chk("t5_exec_ra", ra_a, 5'd10);
    #1 reset = 1'b1;
    #1 check_all_zero_a("t5_async");
    @(negedge clk);
    check_all_zero_a("t5_next");
    @(negedge clk) reset = 1'b0;
    repeat (10) @(negedge clk);
    chk("t5_we_count", we_cnt_a - snap, 2);
    chk("t5_idle", st_a, ST_IDLE);

    // Test 6: EXEC_CYCLES=3, 32 legal words stop on the count limit
    do_reset();
    for (int i = 0; i < 32; i++) exp_qb.push_back(5'((i % 31) + 1));
    @(negedge clk) start_b = 1'b1;
    @(negedge clk) start_b = 1'b0;
    wait_end(1, 400, "t6");
    chk("t6_done", done_b, 1'b1);
    chk("t6_illegal", ill_b, 1'b0);
    chk("t6_cnt", cnt_b, 6'd32);
    chk("t6_we", we_cnt_b, 32);
    chk("t6_fetches", fetch_cnt_b, 32);
    chk("t6_expq_empty", exp_qb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
